// File: rtl/spi_pixel_loader_pkg.sv
// Shared definitions for the SPI pixel loader and the matrix driver it feeds:
// board geometry, value-memory depth, command opcode and loader FSM states.
package spi_pixel_loader_pkg;

   // Matrix geometry shared with the matrix driver.
   localparam int BOARDS     = 4;
   localparam int ROWS       = 3;
   localparam int PIX_DEPTH  = BOARDS * 16 * ROWS;
   localparam int PIX_ADDR_W = 9;

   // Only opcode the loader acts on; anything else discards the transaction.
   localparam logic [7:0] CMD_WRITE = 8'h01;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CMD,
      ST_ADDR_HI,
      ST_ADDR_LO,
      ST_DATA,
      ST_DISCARD
   } state_t;

endpackage

// File: rtl/spi_pixel_loader_pin_sync.sv
// spi_pin_sync: two-flop synchronizers for the SPI pins, plus registered
// single-cycle edge pulses for sclk and cs_n. The sclk falling-edge pulse
// only exists when SPI_STATUS_EN is defined (it clocks the status byte out).
// The cs_n synchronizer resets low so that a chip select already asserted
// at reset release does not look like a fresh falling edge.
module spi_pin_sync
   import spi_pixel_loader_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic i_sclk,
   input  logic i_cs_n,
   input  logic i_mosi,
   output logic o_sclk_rise,
`ifdef SPI_STATUS_EN
   output logic o_sclk_fall,
`endif
   output logic o_cs_rise,
   output logic o_cs_fall,
   output logic o_mosi
);

   logic [1:0] r_sclk_sync;
   logic [1:0] r_cs_sync;
   logic [1:0] r_mosi_sync;
   logic       r_sclk_prev;
   logic       r_cs_prev;
   logic       r_sclk_rise;
   logic       r_cs_rise;
   logic       r_cs_fall;

   // Synchronize the pins and register the edge pulses one cycle after sync.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_sclk_sync <= 2'b00;
         r_cs_sync   <= 2'b00;
         r_mosi_sync <= 2'b00;
         r_sclk_prev <= 1'b0;
         r_cs_prev   <= 1'b0;
         r_sclk_rise <= 1'b0;
         r_cs_rise   <= 1'b0;
         r_cs_fall   <= 1'b0;
      end else begin
         r_sclk_sync <= {r_sclk_sync[0], i_sclk};
         r_cs_sync   <= {r_cs_sync[0], i_cs_n};
         r_mosi_sync <= {r_mosi_sync[0], i_mosi};
         r_sclk_prev <= r_sclk_sync[1];
         r_cs_prev   <= r_cs_sync[1];
         r_sclk_rise <= r_sclk_sync[1] & ~r_sclk_prev;
         r_cs_rise   <= r_cs_sync[1] & ~r_cs_prev;
         r_cs_fall   <= ~r_cs_sync[1] & r_cs_prev;
      end
   end

`ifdef SPI_STATUS_EN
   logic r_sclk_fall;

   // Falling sclk pulse, aligned with the rising one.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_sclk_fall <= 1'b0;
      end else begin
         r_sclk_fall <= ~r_sclk_sync[1] & r_sclk_prev;
      end
   end

   assign o_sclk_fall = r_sclk_fall;
`endif

   assign o_sclk_rise = r_sclk_rise;
   assign o_cs_rise   = r_cs_rise;
   assign o_cs_fall   = r_cs_fall;
   assign o_mosi      = r_mosi_sync[1];

endmodule

// File: rtl/spi_pixel_loader.sv
// spi_pixel_loader: SPI mode-0 slave turning "01 addr_hi addr_lo data..."
// transactions into single-cycle writes into the matrix value memory.
// Optional feature macro SPI_STATUS_EN adds spi_miso, which returns the
// status byte {error, frame_count[6:0]} during the command byte.
module spi_pixel_loader
   import spi_pixel_loader_pkg::*;
#(
   parameter int DEPTH  = PIX_DEPTH,
   parameter int ADDR_W = PIX_ADDR_W
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              spi_sclk,
   input  logic              spi_cs_n,
   input  logic              spi_mosi,
   output logic [ADDR_W-1:0] address_out,
   output logic [7:0]        data_out,
   output logic              write_strobe_out,
   output logic              frame_done
`ifdef SPI_STATUS_EN
   ,
   output logic              spi_miso
`endif
);

   logic w_sclk_rise;
   logic w_cs_rise;
   logic w_cs_fall;
   logic w_mosi;
`ifdef SPI_STATUS_EN
   logic w_sclk_fall;
`endif

   spi_pin_sync u_pin_sync (
      .clk         (clk),
      .rst         (rst),
      .i_sclk      (spi_sclk),
      .i_cs_n      (spi_cs_n),
      .i_mosi      (spi_mosi),
      .o_sclk_rise (w_sclk_rise),
`ifdef SPI_STATUS_EN
      .o_sclk_fall (w_sclk_fall),
`endif
      .o_cs_rise   (w_cs_rise),
      .o_cs_fall   (w_cs_fall),
      .o_mosi      (w_mosi)
   );

   state_t            r_state;
   state_t            w_state_next;
   logic [6:0]        r_shift;
   logic [2:0]        r_bit_cnt;
   logic              r_addr_hi;
   logic [ADDR_W-1:0] r_addr;
   logic              r_wrote;

   logic [7:0]        w_byte;
   logic              w_byte_done;
   logic [8:0]        w_start_addr;
   logic              w_addr_ok;
   logic              w_write;
   logic              w_load_hi;
   logic              w_load_addr;

   // The eighth bit completes the byte combinationally, so a write can be
   // registered on the same cycle the last sclk edge is detected.
   assign w_byte       = {r_shift, w_mosi};
   assign w_byte_done  = w_sclk_rise && (r_bit_cnt == 3'd7) && (r_state != ST_IDLE);
   assign w_start_addr = {r_addr_hi, w_byte};
   assign w_addr_ok    = int'(w_start_addr) < DEPTH;

   // Shift in mosi on each synced sclk rise inside a transaction.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_shift   <= 7'd0;
         r_bit_cnt <= 3'd0;
      end else if (w_cs_fall) begin
         r_bit_cnt <= 3'd0;
      end else if (w_sclk_rise && r_state != ST_IDLE) begin
         r_shift   <= w_byte[6:0];
         r_bit_cnt <= r_bit_cnt + 3'd1;
      end
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next state and per-byte actions; chip-select edges override bytes.
   always_comb begin
      w_state_next = r_state;
      w_write      = 1'b0;
      w_load_hi    = 1'b0;
      w_load_addr  = 1'b0;
      if (w_cs_rise) begin
         w_state_next = ST_IDLE;
      end else if (w_cs_fall) begin
         w_state_next = ST_CMD;
      end else if (w_byte_done) begin
         unique case (r_state)
            ST_CMD: begin
               w_state_next = (w_byte == CMD_WRITE) ? ST_ADDR_HI : ST_DISCARD;
            end
            ST_ADDR_HI: begin
               w_load_hi    = 1'b1;
               w_state_next = ST_ADDR_LO;
            end
            ST_ADDR_LO: begin
               if (w_addr_ok) begin
                  w_load_addr  = 1'b1;
                  w_state_next = ST_DATA;
               end else begin
                  w_state_next = ST_DISCARD;
               end
            end
            ST_DATA: begin
               w_write = 1'b1;
            end
            default: begin
               w_state_next = r_state;
            end
         endcase
      end
   end

   // Address assembly and auto-increment with wrap at the top of memory.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_addr_hi <= 1'b0;
         r_addr    <= '0;
      end else begin
         if (w_load_hi) begin
            r_addr_hi <= w_byte[0];
         end
         if (w_load_addr) begin
            r_addr <= ADDR_W'(w_start_addr);
         end else if (w_write) begin
            r_addr <= (r_addr == ADDR_W'(DEPTH - 1)) ? '0 : r_addr + ADDR_W'(1);
         end
      end
   end

   // Registered write port toward the value memory; address/data hold between strobes.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         address_out      <= '0;
         data_out         <= 8'd0;
         write_strobe_out <= 1'b0;
      end else begin
         write_strobe_out <= w_write;
         if (w_write) begin
            address_out <= r_addr;
            data_out    <= w_byte;
         end
      end
   end

   // Frame-done only for transactions that actually wrote something.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wrote    <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         frame_done <= w_cs_rise & r_wrote;
         if (w_cs_fall || w_cs_rise) begin
            r_wrote <= 1'b0;
         end else if (w_write) begin
            r_wrote <= 1'b1;
         end
      end
   end

`ifdef SPI_STATUS_EN
   logic       r_error;
   logic [6:0] r_frame_count;
   logic [7:0] r_status_sr;

   // Status byte loads at transaction start and walks out during the command
   // byte; the error flag clears once the host has been shown its bit.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_error       <= 1'b0;
         r_frame_count <= 7'd0;
         r_status_sr   <= 8'd0;
      end else begin
         if (w_cs_fall) begin
            r_status_sr <= {r_error, r_frame_count};
         end else if (w_sclk_fall && r_state == ST_CMD) begin
            r_status_sr <= {r_status_sr[6:0], 1'b0};
         end
         if (r_state == ST_ADDR_LO && w_state_next == ST_DISCARD) begin
            r_error <= 1'b1;
         end else if (w_sclk_fall && r_state == ST_CMD && r_bit_cnt == 3'd1) begin
            r_error <= 1'b0;
         end
         if (w_cs_rise && r_wrote) begin
            r_frame_count <= r_frame_count + 7'd1;
         end
      end
   end

   assign spi_miso = (r_state == ST_CMD) ? r_status_sr[7] : 1'b0;
`endif

endmodule

// File: tb/tb_spi_pixel_loader.sv
// Self-checking bench for spi_pixel_loader. Drives SPI transactions, records
// every write strobe and frame_done, and compares against a transaction-level
// model. Status readback checks compile in when SPI_STATUS_EN is defined.
module tb_spi_pixel_loader;

   localparam int DEPTH = 192;
   localparam int HALF  = 6;

   logic       clk = 1'b0;
   logic       rst;
   logic       spi_sclk;
   logic       spi_cs_n;
   logic       spi_mosi;
   logic [8:0] address_out;
   logic [7:0] data_out;
   logic       write_strobe_out;
   logic       frame_done;
`ifdef SPI_STATUS_EN
   logic       spi_miso;
`endif

   spi_pixel_loader #(.DEPTH(DEPTH), .ADDR_W(9)) dut (
      .clk              (clk),
      .rst              (rst),
      .spi_sclk         (spi_sclk),
      .spi_cs_n         (spi_cs_n),
      .spi_mosi         (spi_mosi),
      .address_out      (address_out),
      .data_out         (data_out),
      .write_strobe_out (write_strobe_out),
      .frame_done       (frame_done)
`ifdef SPI_STATUS_EN
      ,
      .spi_miso         (spi_miso)
`endif
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   int cap_q[$];
   int fd_cnt, fd_lat, strobe_lat, overlap_cnt;
   int last_rise_cyc, cs_rise_cyc;

   logic [7:0] tx_q[$];
   int         exp_q[$];
   bit         exp_err;
   logic [7:0] exp_status;
   logic [7:0] miso_byte;
   bit         m_err;
   int         m_fc;

   always @(posedge clk) cyc <= cyc + 1;

   // Observe outputs mid-cycle.
   always @(negedge clk) begin
      if (write_strobe_out === 1'b1) begin
         cap_q.push_back({15'd0, address_out, data_out});
         strobe_lat = cyc - last_rise_cyc;
      end
      if (frame_done === 1'b1) begin
         fd_cnt++;
         fd_lat = cyc - cs_rise_cyc;
         if (write_strobe_out === 1'b1) overlap_cnt++;
      end
   end

   initial begin
      #10ms;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic cs_fall();
      @(negedge clk);
      spi_cs_n = 1'b0;
      wait_clk(HALF);
   endtask

   task automatic cs_rise();
      wait_clk(HALF);
      spi_cs_n    = 1'b1;
      cs_rise_cyc = cyc;
      wait_clk(16);
   endtask

   task automatic send_bits(input logic [7:0] b, input int nbits, input bit grab);
      for (int i = 7; i > 7 - nbits; i--) begin
         spi_mosi = b[i];
         wait_clk(HALF);
         if (grab) begin
`ifdef SPI_STATUS_EN
            miso_byte[i] = spi_miso;
`else
            miso_byte[i] = 1'b0;
`endif
         end
         spi_sclk      = 1'b1;
         last_rise_cyc = cyc;
         wait_clk(HALF);
         spi_sclk = 1'b0;
      end
   endtask

   task automatic clear_capture();
      cap_q.delete();
      fd_cnt      = 0;
      overlap_cnt = 0;
      fd_lat      = -1;
      strobe_lat  = -1;
      miso_byte   = 8'h00;
   endtask

   // Full transaction of the bytes in tx_q, optionally followed by a partial byte.
   task automatic do_txn(input int extra_bits);
      logic [7:0] junk;
      clear_capture();
      cs_fall();
      for (int k = 0; k < tx_q.size(); k++) send_bits(tx_q[k], 8, k == 0);
      if (extra_bits > 0) begin
         junk = 8'($urandom);
         send_bits(junk, extra_bits, 1'b0);
      end
      cs_rise();
   endtask

   // Transaction-level reference: decode tx_q by the protocol rules.
   function automatic void model_txn();
      int a;
      exp_q.delete();
      exp_err    = 1'b0;
      exp_status = {m_err, 7'(m_fc)};
      if (tx_q.size() > 0) m_err = 1'b0;
      if (tx_q.size() >= 3 && tx_q[0] == 8'h01) begin
         a = int'(tx_q[1][0]) * 256 + int'(tx_q[2]);
         if (a >= DEPTH) begin
            exp_err = 1'b1;
         end else begin
            for (int i = 3; i < tx_q.size(); i++) begin
               exp_q.push_back(a * 256 + int'(tx_q[i]));
               a = (a + 1) % DEPTH;
            end
         end
      end
      if (exp_err) m_err = 1'b1;
      if (exp_q.size() > 0) m_fc = (m_fc + 1) % 128;
   endfunction

   task automatic test_reset();
      rst = 1'b0; spi_cs_n = 1'b1; spi_sclk = 1'b0; spi_mosi = 1'b0;
      m_err = 1'b0; m_fc = 0;
      wait_clk(5);
      n_checks++;
      if ({address_out, data_out, write_strobe_out, frame_done} !== 19'd0) begin
         n_fail++;
         $display("FAIL reset_during: outputs %h, required 0", {address_out, data_out, write_strobe_out, frame_done});
      end
      rst = 1'b1;
      wait_clk(8);
      n_checks++;
      if ({address_out, data_out, write_strobe_out, frame_done} !== 19'd0) begin
         n_fail++;
         $display("FAIL reset_after: outputs %h, required 0", {address_out, data_out, write_strobe_out, frame_done});
      end
`ifdef SPI_STATUS_EN
      n_checks++;
      if (spi_miso !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_miso: miso %b, required 0", spi_miso);
      end
`endif
      $display("txn reset: outputs checked");
   endtask

   task automatic test_basic();
      tx_q = '{8'h01, 8'h00, 8'h05, 8'hAA, 8'hBB};
      model_txn();
      do_txn(0);
      n_checks++;
      if (cap_q.size() !== 2) begin
         n_fail++; $display("FAIL basic_count: got %0d strobes, required 2", cap_q.size());
      end
      n_checks++;
      if (cap_q.size() < 1 || cap_q[0] !== 32'h05AA) begin
         n_fail++; $display("FAIL basic_w0: got %h, required 05aa", cap_q.size() > 0 ? cap_q[0] : -1);
      end
      n_checks++;
      if (cap_q.size() < 2 || cap_q[1] !== 32'h06BB) begin
         n_fail++; $display("FAIL basic_w1: got %h, required 06bb", cap_q.size() > 1 ? cap_q[1] : -1);
      end
      n_checks++;
      if (fd_cnt !== 1) begin
         n_fail++; $display("FAIL basic_fd: got %0d frame_done, required 1", fd_cnt);
      end
      n_checks++;
      if (strobe_lat !== 4) begin
         n_fail++; $display("FAIL basic_strobe_lat: got %0d cycles, required 4", strobe_lat);
      end
      n_checks++;
      if (fd_lat !== 4) begin
         n_fail++; $display("FAIL basic_fd_lat: got %0d cycles, required 4", fd_lat);
      end
      n_checks++;
      if (address_out !== 9'd6 || data_out !== 8'hBB) begin
         n_fail++; $display("FAIL basic_hold: got %0d/%h, required 6/bb", address_out, data_out);
      end
      n_checks++;
      if (overlap_cnt !== 0) begin
         n_fail++; $display("FAIL basic_overlap: got %0d, required 0", overlap_cnt);
      end
      $display("txn basic: %0d strobes, %0d frame_done, lat %0d", cap_q.size(), fd_cnt, strobe_lat);
   endtask

   task automatic test_wrap();
      int addrs[4] = '{190, 191, 0, 1};
      tx_q = '{8'h01, 8'h00, 8'hBE};
      for (int i = 0; i < 4; i++) tx_q.push_back(8'($urandom));
      model_txn();
      do_txn(0);
      n_checks++;
      if (cap_q.size() !== 4) begin
         n_fail++; $display("FAIL wrap_count: got %0d strobes, required 4", cap_q.size());
      end
      for (int i = 0; i < 4 && i < cap_q.size(); i++) begin
         n_checks++;
         if (cap_q[i] !== addrs[i] * 256 + int'(tx_q[3 + i])) begin
            n_fail++;
            $display("FAIL wrap_w%0d: got %h, required %h", i, cap_q[i], addrs[i] * 256 + int'(tx_q[3 + i]));
         end
      end
      n_checks++;
      if (fd_cnt !== 1) begin
         n_fail++; $display("FAIL wrap_fd: got %0d, required 1", fd_cnt);
      end
      $display("txn wrap: %0d strobes", cap_q.size());
   endtask

   task automatic test_rejects();
      // Bad opcode, then out-of-range start address.
      tx_q = '{8'h02, 8'h00, 8'h05, 8'h11, 8'h22};
      model_txn();
      do_txn(0);
      n_checks++;
      if (cap_q.size() !== 0 || fd_cnt !== 0) begin
         n_fail++; $display("FAIL badcmd: got %0d strobes %0d fd, required 0 0", cap_q.size(), fd_cnt);
      end
      $display("txn bad_cmd: %0d strobes", cap_q.size());
      tx_q = '{8'h01, 8'h00, 8'hC0, 8'h33, 8'h44};
      model_txn();
      do_txn(0);
      n_checks++;
      if (cap_q.size() !== 0 || fd_cnt !== 0) begin
         n_fail++; $display("FAIL badaddr: got %0d strobes %0d fd, required 0 0", cap_q.size(), fd_cnt);
      end
      $display("txn bad_addr: %0d strobes", cap_q.size());
      tx_q = '{8'h01, 8'h00, 8'h10, 8'h5A};
      model_txn();
      do_txn(0);
      n_checks++;
      if (cap_q.size() !== 1 || cap_q[0] !== 32'h105A) begin
         n_fail++; $display("FAIL after_bad: got %0d strobes, required one write 10/5a", cap_q.size());
      end
`ifdef SPI_STATUS_EN
      n_checks++;
      if (miso_byte[7] !== 1'b1) begin
         n_fail++; $display("FAIL status_err_set: miso %h, required bit7=1", miso_byte);
      end
      tx_q = '{8'h03};
      model_txn();
      do_txn(0);
      n_checks++;
      if (miso_byte[7] !== 1'b0) begin
         n_fail++; $display("FAIL status_err_clr: miso %h, required bit7=0", miso_byte);
      end
`endif
      $display("txn after_bad: %0d strobes miso %h", cap_q.size(), miso_byte);
   endtask

   task automatic test_partial();
      tx_q = '{8'h01, 8'h00, 8'h00};
      model_txn();
      do_txn(3);
      n_checks++;
      if (cap_q.size() !== 0 || fd_cnt !== 0) begin
         n_fail++; $display("FAIL partial: got %0d strobes %0d fd, required 0 0", cap_q.size(), fd_cnt);
      end
      tx_q = '{8'h01, 8'h00, 8'h30, 8'h77, 8'h88};
      model_txn();
      do_txn(0);
      n_checks++;
      if (cap_q.size() !== 2 || cap_q[0] !== 32'h3077 || cap_q[1] !== 32'h3188 || fd_cnt !== 1) begin
         n_fail++; $display("FAIL after_partial: got %0d strobes %0d fd, required 30/77 31/88 fd 1", cap_q.size(), fd_cnt);
      end
      $display("txn partial: next txn %0d strobes", cap_q.size());
   endtask

   task automatic test_reset_mid();
      clear_capture();
      cs_fall();
      send_bits(8'h01, 8, 1'b0);
      send_bits(8'h00, 8, 1'b0);
      send_bits(8'h05, 8, 1'b0);
      send_bits(8'h11, 8, 1'b0);
      send_bits(8'h22, 8, 1'b0);
      wait_clk(2);
      rst = 1'b0;
      #1;
      n_checks++;
      if ({address_out, data_out, write_strobe_out, frame_done} !== 19'd0) begin
         n_fail++; $display("FAIL rstmid_outputs: %h, required 0", {address_out, data_out, write_strobe_out, frame_done});
      end
      m_err = 1'b0; m_fc = 0;
      wait_clk(3);
      rst = 1'b1;
      wait_clk(4);
      clear_capture();
      send_bits(8'h01, 8, 1'b0);
      send_bits(8'h00, 8, 1'b0);
      send_bits(8'h07, 8, 1'b0);
      send_bits(8'h55, 8, 1'b0);
      cs_rise();
      n_checks++;
      if (cap_q.size() !== 0 || fd_cnt !== 0) begin
         n_fail++; $display("FAIL rstmid_idle: got %0d strobes %0d fd, required 0 0", cap_q.size(), fd_cnt);
      end
      tx_q = '{8'h01, 8'h00, 8'h05, 8'hAA, 8'hBB};
      model_txn();
      do_txn(0);
      n_checks++;
      if (cap_q.size() !== 2 || cap_q[0] !== 32'h05AA || cap_q[1] !== 32'h06BB || fd_cnt !== 1) begin
         n_fail++; $display("FAIL rstmid_restart: got %0d strobes %0d fd, required 05/aa 06/bb fd 1", cap_q.size(), fd_cnt);
      end
`ifdef SPI_STATUS_EN
      n_checks++;
      if (miso_byte !== 8'h00) begin
         n_fail++; $display("FAIL rstmid_status: miso %h, required 00", miso_byte);
      end
`endif
      $display("txn reset_mid: restart %0d strobes", cap_q.size());
   endtask

`ifdef SPI_STATUS_EN
   task automatic test_status();
      logic [7:0] a;
      @(negedge clk);
      rst = 1'b0;
      wait_clk(3);
      rst = 1'b1;
      wait_clk(4);
      m_err = 1'b0; m_fc = 0;
      for (int f = 0; f < 3; f++) begin
         a    = 8'($urandom_range(0, DEPTH - 1));
         tx_q = '{8'h01, 8'h00, a, 8'($urandom)};
         model_txn();
         do_txn(0);
      end
      tx_q = '{8'h02};
      model_txn();
      do_txn(0);
      n_checks++;
      if (miso_byte !== 8'h03) begin
         n_fail++; $display("FAIL status_count: miso %h, required 03", miso_byte);
      end
      $display("txn status: miso %h", miso_byte);
   endtask
`endif

   task automatic test_random();
      logic [8:0] a9;
      logic [7:0] rb;
      int         nd, extra;
      for (int t = 0; t < 12; t++) begin
         a9 = 9'($urandom_range(0, 215));
         rb = 8'($urandom);
         tx_q.delete();
         tx_q.push_back(($urandom_range(0, 7) == 0) ? 8'h04 : 8'h01);
         tx_q.push_back({rb[7:1], a9[8]});
         tx_q.push_back(a9[7:0]);
         nd = $urandom_range(0, 5);
         for (int i = 0; i < nd; i++) tx_q.push_back(8'($urandom));
         extra = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 7) : 0;
         model_txn();
         do_txn(extra);
         n_checks++;
         if (cap_q.size() !== exp_q.size()) begin
            n_fail++; $display("FAIL rand%0d_count: got %0d strobes, required %0d", t, cap_q.size(), exp_q.size());
         end
         for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
            n_checks++;
            if (cap_q[i] !== exp_q[i]) begin
               n_fail++; $display("FAIL rand%0d_w%0d: got %h, required %h", t, i, cap_q[i], exp_q[i]);
            end
         end
         n_checks++;
         if (fd_cnt !== ((exp_q.size() > 0) ? 1 : 0) || overlap_cnt !== 0) begin
            n_fail++; $display("FAIL rand%0d_fd: got %0d (overlap %0d), required %0d", t, fd_cnt, overlap_cnt, (exp_q.size() > 0) ? 1 : 0);
         end
`ifdef SPI_STATUS_EN
         n_checks++;
         if (miso_byte !== exp_status) begin
            n_fail++; $display("FAIL rand%0d_status: miso %h, required %h", t, miso_byte, exp_status);
         end
`endif
         $display("txn rand%0d: cmd %h addr %0d data %0d extra %0d -> %0d strobes, %0d fd", t, tx_q[0], a9, nd, extra, cap_q.size(), fd_cnt);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_wrap();
      test_rejects();
      test_partial();
      test_reset_mid();
`ifdef SPI_STATUS_EN
      test_status();
`endif
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
